trap_seq: RTL and testbench
===========================

# trap_seq

Machine-mode trap and return sequencer sitting between the decode stage and the CSR register file. On an `ecall`/`ebreak`, an accepted timer or external interrupt, or an `mret`, it stalls the pipeline, writes `mepc`, `mcause` and `mstatus` through the CSR file's secondary write port, and issues a redirect to `mtvec` or `mepc`. It owns that port exclusively and never collides with write-back CSR traffic.

## Interface
- `MTVEC_ALIGN`, default 2: number of low `mtvec` bits forced to zero on trap entry (direct mode only).
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `id_ecall` in 1: decode holds `ecall` this cycle.
- `id_ebreak` in 1: decode holds `ebreak` this cycle.
- `id_mret` in 1: decode holds `mret` this cycle.
- `id_pc` in 32: address of the instruction in decode.
- `irq_timer` in 1: level timer interrupt request.
- `irq_ext` in 1: level external interrupt request.
- `global_int_en` in 1: `mstatus.MIE` from the CSR file.
- `csr_mtvec` in 32: current `mtvec` from the CSR file.
- `csr_mepc` in 32: current `mepc` from the CSR file.
- `csr_mstatus` in 32: current `mstatus` from the CSR file.
- `wb_csr_we` in 1: write-back stage writing a CSR this cycle.
- `hold` out 1: pipeline stall request.
- `csr_we` out 1: CSR write enable.
- `csr_waddr` out 32: CSR write address, bits 31:12 zero.
- `csr_wdata` out 32: CSR write data.
- `jump_flag` out 1: one-cycle redirect and flush.
- `jump_addr` out 32: redirect target.
- `irq_ack` out 1: one-cycle pulse when an interrupt is accepted.

## Operation
- States: IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, R_MSTATUS, JUMP.
- In IDLE, events are taken in this priority order: ecall > ebreak > mret > external interrupt > timer interrupt.
- Interrupts are taken only when `global_int_en` is 1.
- On an accepted event in IDLE:
  - latch `pc_q = id_pc`.
  - latch `cause_q`: ecall 0x0000000B, ebreak 0x00000003, external 0x8000000B, timer 0x80000007.
  - latch the kind, trap or return.
  - go to W_MEPC for a trap, R_MSTATUS for `mret`.
- `irq_ack` pulses in the acceptance cycle for interrupts only.
- W_MEPC: `csr_waddr` 0x341, `csr_wdata` = `pc_q`.
- W_MCAUSE: `csr_waddr` 0x342, `csr_wdata` = `cause_q`.
- W_MSTATUS (trap entry): `csr_waddr` 0x300, `csr_wdata` = `csr_mstatus` with bit 7 (MPIE) = `csr_mstatus[3]` and bit 3 (MIE) = 0. All other bits pass through.
- R_MSTATUS (`mret`): `csr_waddr` 0x300, `csr_wdata` = `csr_mstatus` with bit 3 = `csr_mstatus[7]` and bit 7 = 1.
- Write states assert `csr_we` only when `wb_csr_we` = 0.
  - If `wb_csr_we` = 1, the state is held and `csr_we` stays 0 (wait cycle).
  - This guarantees write-back always has sole use of the write port.
- JUMP: `jump_flag` = 1 for one cycle, then return to IDLE.
  - Trap: `jump_addr` = `csr_mtvec` with its low `MTVEC_ALIGN` bits cleared.
  - Return: `jump_addr` = `csr_mepc`.
- `mepc` for interrupts is `id_pc`: the decode instruction is discarded and re-executed after `mret`.
- Events arriving outside IDLE are ignored. The pipeline is held, so sync events stay in decode; interrupt levels are held by their requester.

## Timing
- Reset: state IDLE; `hold`, `csr_we`, `jump_flag`, `irq_ack` = 0; `csr_waddr`, `csr_wdata`, `jump_addr` = 0; `pc_q`, `cause_q` = 0.
- Reset mid-sequence aborts immediately with no further CSR writes.
- `hold` is combinational:
  - 1 in the IDLE cycle where an event is accepted.
  - 1 in every non-IDLE state, including JUMP.
  - 0 from the cycle after JUMP.
- Outputs are combinational from state and latched values. Writes commit on the next rising edge.
- Trap latency with no wait cycles: accept at cycle 0, MEPC write in cycle 1, MCAUSE in cycle 2, MSTATUS in cycle 3, `jump_flag` in cycle 4.
- `mret` latency with no wait cycles: accept at cycle 0, MSTATUS write in cycle 1, `jump_flag` in cycle 2.
- Each cycle with `wb_csr_we` = 1 in a write state adds exactly one cycle.
- W_MSTATUS and R_MSTATUS sample `csr_mstatus` in their write cycle, so any write-back update committed during wait cycles is honoured.
- JUMP samples `csr_mtvec`/`csr_mepc` in the JUMP cycle, so the redirect uses post-write values.
- A new event can be accepted in the IDLE cycle immediately after JUMP. There is no back-to-back acceptance inside JUMP.

## Test plan
- Ecall trap: `id_ecall` = 1, `id_pc` = 0x00000100, `csr_mtvec` = 0x00000203, `csr_mstatus` = 0x00000008.
  - Required writes: 0x341←0x100 in cycle 1, 0x342←0x0000000B in cycle 2, 0x300←0x00000080 in cycle 3.
  - Cycle 4: `jump_flag` = 1, `jump_addr` = 0x00000200. `hold` is 1 in cycles 0-4 and 0 in cycle 5.
- Mret: `id_mret` = 1, `csr_mstatus` = 0x00000080, `csr_mepc` = 0x00000104.
  - Cycle 1: write 0x300←0x00000088. Cycle 2: jump to 0x104.
- Timer interrupt gating: `irq_timer` = 1 with `global_int_en` = 0 gives no `hold` over 10 cycles.
  - Raise `global_int_en` to 1: `irq_ack` pulses, `mcause` is written 0x80000007, `mepc` is written `id_pc`.
- Priority: `id_ebreak` = 1, `irq_ext` = 1, `irq_timer` = 1 all asserted, `global_int_en` = 1.
  - Cause 0x00000003 is written and `irq_ack` stays 0.
- Port conflict: `wb_csr_we` = 1 during cycles 2-3 of an ecall sequence.
  - `csr_we` = 0 in those cycles; the MCAUSE write lands in cycle 4 and `jump_flag` appears in cycle 6.
- Reset abort: assert `rst` in the W_MCAUSE cycle.
  - All outputs are 0 the next cycle; no 0x300 write occurs; `hold` is 0.

Source files
------------

// File: rtl/trap_seq.sv
// trap_seq: machine-mode trap-entry and mret sequencer. Owns the CSR file's
// secondary write port and drives the pipeline stall and redirect.
module trap_seq #(
  parameter int unsigned MTVEC_ALIGN = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_ecall,
  input  logic        id_ebreak,
  input  logic        id_mret,
  input  logic [31:0] id_pc,
  input  logic        irq_timer,
  input  logic        irq_ext,
  input  logic        global_int_en,
  input  logic [31:0] csr_mtvec,
  input  logic [31:0] csr_mepc,
  input  logic [31:0] csr_mstatus,
  input  logic        wb_csr_we,
  output logic        hold,
  output logic        csr_we,
  output logic [31:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        jump_flag,
  output logic [31:0] jump_addr,
  output logic        irq_ack
);

  localparam logic [31:0] CAUSE_ECALL  = 32'h0000_000B;
  localparam logic [31:0] CAUSE_EBREAK = 32'h0000_0003;
  localparam logic [31:0] CAUSE_EXT    = 32'h8000_000B;
  localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;
  localparam logic [31:0] ADDR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] ADDR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] ADDR_MCAUSE  = 32'h0000_0342;
  localparam logic [31:0] MTVEC_MASK   = ~((32'd1 << MTVEC_ALIGN) - 32'd1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_W_MEPC    = 3'd1,
    S_W_MCAUSE  = 3'd2,
    S_W_MSTATUS = 3'd3,
    S_R_MSTATUS = 3'd4,
    S_JUMP      = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cause_q, cause_d;
  logic        ret_q, ret_d;

  logic        accept_s;
  logic        hold_s, csr_we_s, jump_flag_s, irq_ack_s;
  logic [31:0] csr_waddr_s, csr_wdata_s, jump_addr_s;

  // Trap entry: save MIE into MPIE, then disable interrupts.
  function automatic logic [31:0] mstatus_on_trap(input logic [31:0] ms);
    logic [31:0] r;
    r    = ms;
    r[7] = ms[3];
    r[3] = 1'b0;
    return r;
  endfunction

  // mret: restore MIE from MPIE and set MPIE.
  function automatic logic [31:0] mstatus_on_ret(input logic [31:0] ms);
    logic [31:0] r;
    r    = ms;
    r[3] = ms[7];
    r[7] = 1'b1;
    return r;
  endfunction

  // Next-state and combinational output decode.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cause_d     = cause_q;
    ret_d       = ret_q;
    accept_s    = 1'b0;
    hold_s      = 1'b0;
    csr_we_s    = 1'b0;
    csr_waddr_s = 32'd0;
    csr_wdata_s = 32'd0;
    jump_flag_s = 1'b0;
    jump_addr_s = 32'd0;
    irq_ack_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (id_ecall) begin
          accept_s = 1'b1;
          cause_d  = CAUSE_ECALL;
          ret_d    = 1'b0;
        end else if (id_ebreak) begin
          accept_s = 1'b1;
          cause_d  = CAUSE_EBREAK;
          ret_d    = 1'b0;
        end else if (id_mret) begin
          accept_s = 1'b1;
          ret_d    = 1'b1;
        end else if (irq_ext && global_int_en) begin
          accept_s  = 1'b1;
          irq_ack_s = 1'b1;
          cause_d   = CAUSE_EXT;
          ret_d     = 1'b0;
        end else if (irq_timer && global_int_en) begin
          accept_s  = 1'b1;
          irq_ack_s = 1'b1;
          cause_d   = CAUSE_TIMER;
          ret_d     = 1'b0;
        end else begin
          accept_s = 1'b0;
        end
        if (accept_s) begin
          hold_s  = 1'b1;
          pc_d    = id_pc;
          state_d = ret_d ? S_R_MSTATUS : S_W_MEPC;
        end else begin
          hold_s = 1'b0;
        end
      end
      S_W_MEPC: begin
        hold_s      = 1'b1;
        csr_waddr_s = ADDR_MEPC;
        csr_wdata_s = pc_q;
        if (!wb_csr_we) begin
          csr_we_s = 1'b1;
          state_d  = S_W_MCAUSE;
        end else begin
          csr_we_s = 1'b0;
        end
      end
      S_W_MCAUSE: begin
        hold_s      = 1'b1;
        csr_waddr_s = ADDR_MCAUSE;
        csr_wdata_s = cause_q;
        if (!wb_csr_we) begin
          csr_we_s = 1'b1;
          state_d  = S_W_MSTATUS;
        end else begin
          csr_we_s = 1'b0;
        end
      end
      S_W_MSTATUS: begin
        hold_s      = 1'b1;
        csr_waddr_s = ADDR_MSTATUS;
        csr_wdata_s = mstatus_on_trap(csr_mstatus);
        if (!wb_csr_we) begin
          csr_we_s = 1'b1;
          state_d  = S_JUMP;
        end else begin
          csr_we_s = 1'b0;
        end
      end
      S_R_MSTATUS: begin
        hold_s      = 1'b1;
        csr_waddr_s = ADDR_MSTATUS;
        csr_wdata_s = mstatus_on_ret(csr_mstatus);
        if (!wb_csr_we) begin
          csr_we_s = 1'b1;
          state_d  = S_JUMP;
        end else begin
          csr_we_s = 1'b0;
        end
      end
      S_JUMP: begin
        hold_s      = 1'b1;
        jump_flag_s = 1'b1;
        jump_addr_s = ret_q ? csr_mepc : (csr_mtvec & MTVEC_MASK);
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A reset cycle suppresses everything so an aborted sequence commits nothing.
  assign hold      = hold_s & ~rst;
  assign csr_we    = csr_we_s & ~rst;
  assign jump_flag = jump_flag_s & ~rst;
  assign irq_ack   = irq_ack_s & ~rst;
  assign csr_waddr = rst ? 32'd0 : csr_waddr_s;
  assign csr_wdata = rst ? 32'd0 : csr_wdata_s;
  assign jump_addr = rst ? 32'd0 : jump_addr_s;

  // State and latched-event registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= 32'd0;
      cause_q <= 32'd0;
      ret_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      ret_q   <= ret_d;
    end
  end

endmodule

// File: tb/tb_trap_seq.sv
// tb_trap_seq: scoreboard bench for trap_seq; a tiny CSR-file model feeds the
// DUT and predicts every write and redirect with its cycle.
module tb_trap_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_ecall, id_ebreak, id_mret;
  logic [31:0] id_pc;
  logic        irq_timer, irq_ext, global_int_en;
  logic [31:0] csr_mtvec, csr_mepc, csr_mstatus;
  logic        wb_csr_we;
  logic        hold, csr_we, jump_flag, irq_ack;
  logic [31:0] csr_waddr, csr_wdata, jump_addr;

  logic [31:0] mtvec_m, mepc_m, mstatus_m, mcause_m;

  typedef struct packed {
    logic        jmp;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   nvec = 0;
  int   fails = 0;

  assign csr_mtvec   = mtvec_m;
  assign csr_mepc    = mepc_m;
  assign csr_mstatus = mstatus_m;

  trap_seq #(.MTVEC_ALIGN(2)) dut (
    .clk(clk), .rst(rst),
    .id_ecall(id_ecall), .id_ebreak(id_ebreak), .id_mret(id_mret), .id_pc(id_pc),
    .irq_timer(irq_timer), .irq_ext(irq_ext), .global_int_en(global_int_en),
    .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc), .csr_mstatus(csr_mstatus),
    .wb_csr_we(wb_csr_we),
    .hold(hold), .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .jump_flag(jump_flag), .jump_addr(jump_addr), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  // Monitor: every write or redirect the DUT presents must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (csr_we || jump_flag)) begin
      if (sb.size() == 0) begin
        nvec++;
        fails++;
        $display("FAIL unexpected_out: we=%0b jump=%0b waddr=%h wdata=%h jaddr=%h required none",
                 csr_we, jump_flag, csr_waddr, csr_wdata, jump_addr);
      end else begin
        e = sb.pop_front();
        chk("out_kind_jump", 32'(jump_flag), 32'(e.jmp));
        chk("out_kind_we", 32'(csr_we), 32'(!e.jmp));
        chk("out_cycle", 32'(cyc), e.cyc);
        if (e.jmp) begin
          chk("jump_addr", jump_addr, e.data);
        end else begin
          chk("csr_waddr", csr_waddr, e.addr);
          chk("csr_wdata", csr_wdata, e.data);
        end
      end
    end
  end

  function automatic logic [31:0] ms_trap(input logic [31:0] ms);
    return {ms[31:8], ms[3], ms[6:4], 1'b0, ms[2:0]};
  endfunction

  function automatic logic [31:0] ms_ret(input logic [31:0] ms);
    return {ms[31:8], 1'b1, ms[6:4], ms[7], ms[2:0]};
  endfunction

  // One decode-stage event, called right after a rising edge; wbm[k] is the
  // write-back port usage in cycle k after acceptance.
  task automatic run_seq(input bit ec, input bit eb, input bit mr, input bit ext, input bit tmr,
                         input bit gie, input logic [31:0] pc, input logic [15:0] wbm);
    int          ev;
    int          start;
    int          cur;
    int          n;
    logic [31:0] wa [3];
    logic [31:0] wd [3];
    logic [31:0] causes [5];
    bit          pend;
    logic [31:0] pa, pdat;
    causes = '{32'h0000_000B, 32'h0000_0003, 32'h0, 32'h8000_000B, 32'h8000_0007};
    if (ec) ev = 0;
    else if (eb) ev = 1;
    else if (mr) ev = 2;
    else if (ext && gie) ev = 3;
    else if (tmr && gie) ev = 4;
    else ev = -1;
    id_ecall = ec; id_ebreak = eb; id_mret = mr; irq_ext = ext; irq_timer = tmr;
    global_int_en = gie; id_pc = pc; wb_csr_we = 1'b0;
    start = cyc;
    if (ev < 0) begin
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        chk("idle_hold", 32'(hold), 32'd0);
        chk("idle_ack", 32'(irq_ack), 32'd0);
        @(posedge clk); #1;
      end
      return;
    end
    if (ev == 2) begin
      n = 1;
      wa[0] = 32'h300; wd[0] = ms_ret(mstatus_m);
    end else begin
      n = 3;
      wa[0] = 32'h341; wd[0] = pc;
      wa[1] = 32'h342; wd[1] = causes[ev];
      wa[2] = 32'h300; wd[2] = ms_trap(mstatus_m);
    end
    cur = 1;
    for (int w = 0; w < n; w++) begin
      while (wbm[cur]) cur++;
      sb.push_back({1'b0, wa[w], wd[w], 32'(start + cur)});
      cur++;
    end
    sb.push_back({1'b1, 32'd0, (ev == 2) ? mepc_m : (mtvec_m & ~32'h3), 32'(start + cur)});
    for (int k = 0; k <= cur + 1; k++) begin
      wb_csr_we = (k < 16) ? wbm[k] : 1'b0;
      if (k == cur + 1) begin
        id_ecall = 1'b0; id_ebreak = 1'b0; id_mret = 1'b0; irq_ext = 1'b0; irq_timer = 1'b0;
        wb_csr_we = 1'b0;
      end
      @(negedge clk);
      chk("hold", 32'(hold), (k <= cur) ? 32'd1 : 32'd0);
      chk("irq_ack", 32'(irq_ack), (k == 0 && ev >= 3) ? 32'd1 : 32'd0);
      pend = csr_we; pa = csr_waddr; pdat = csr_wdata;
      @(posedge clk); #1;
      if (pend) begin
        case (pa)
          32'h341: mepc_m = pdat;
          32'h342: mcause_m = pdat;
          32'h300: mstatus_m = pdat;
          default: ;
        endcase
      end
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    rst = 1'b1;
    id_ecall = 1'b0; id_ebreak = 1'b0; id_mret = 1'b0; id_pc = 32'd0;
    irq_timer = 1'b0; irq_ext = 1'b0; global_int_en = 1'b0; wb_csr_we = 1'b0;
    mtvec_m = 32'd0; mepc_m = 32'd0; mstatus_m = 32'd0; mcause_m = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_hold", 32'(hold), 32'd0);
    chk("rst_we", 32'(csr_we), 32'd0);
    chk("rst_jump", 32'(jump_flag), 32'd0);
    chk("rst_ack", 32'(irq_ack), 32'd0);
    chk("rst_waddr", csr_waddr, 32'd0);
    chk("rst_wdata", csr_wdata, 32'd0);
    chk("rst_jaddr", jump_addr, 32'd0);
    @(posedge clk); #1;

    // Ecall trap entry.
    mtvec_m = 32'h0000_0203; mstatus_m = 32'h0000_0008;
    run_seq(1, 0, 0, 0, 0, 0, 32'h0000_0100, 16'h0000);
    // Mret.
    mstatus_m = 32'h0000_0080; mepc_m = 32'h0000_0104;
    run_seq(0, 0, 1, 0, 0, 0, 32'h0000_0200, 16'h0000);
    // Timer gated, then enabled.
    run_seq(0, 0, 0, 0, 1, 0, 32'h0000_0300, 16'h0000);
    run_seq(0, 0, 0, 0, 1, 1, 32'h0000_0300, 16'h0000);
    // Priority: ebreak beats both interrupts.
    run_seq(0, 1, 0, 1, 1, 1, 32'h0000_0404, 16'h0000);
    // External beats timer.
    run_seq(0, 0, 0, 1, 1, 1, 32'h0000_0408, 16'h0000);
    // Write-back port busy in cycles 2-3.
    run_seq(1, 0, 0, 0, 0, 0, 32'h0000_0500, 16'h000C);
    // Busy write-back during the mret write.
    mstatus_m = 32'h0000_0000;
    run_seq(0, 0, 1, 0, 0, 0, 32'h0000_0600, 16'h0006);

    // Reset in the W_MCAUSE cycle aborts the sequence.
    id_ecall = 1'b1; id_pc = 32'h0000_0700; wb_csr_we = 1'b0;
    sb.push_back({1'b0, 32'h341, 32'h0000_0700, 32'(cyc + 1)});
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    if (csr_we) mepc_m = csr_wdata;
    rst = 1'b1; id_ecall = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_hold", 32'(hold), 32'd0);
    chk("abort_we", 32'(csr_we), 32'd0);
    chk("abort_jump", 32'(jump_flag), 32'd0);
    chk("abort_ack", 32'(irq_ack), 32'd0);
    chk("abort_waddr", csr_waddr, 32'd0);
    chk("abort_wdata", csr_wdata, 32'd0);
    chk("abort_jaddr", jump_addr, 32'd0);
    repeat (6) @(negedge clk);
    chk("abort_sb_drained", 32'(sb.size()), 32'd0);
    sb.delete();
    @(posedge clk); #1;

    // Randomized events with sparse write-back contention.
    for (int i = 0; i < 60; i++) begin
      logic [4:0]  req;
      logic [15:0] wbm;
      req = 5'($urandom) & 5'($urandom);
      wbm = 16'($urandom) & 16'($urandom) & 16'h01FE;
      mtvec_m = $urandom;
      if ($urandom_range(0, 3) == 0) mstatus_m = $urandom;
      if ($urandom_range(0, 3) == 0) mepc_m = $urandom & 32'hFFFF_FFFC;
      run_seq(req[0], req[1], req[2], req[3], req[4], 1'($urandom), $urandom & 32'hFFFF_FFFC, wbm);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, fails);
    $finish;
  end

endmodule
